vscale_dmem_bridge: RTL and testbench

Downstream consumer of the pipeline's data-memory port. Accepts the pipeline's split address-phase/data-phase request (write data arrives one cycle after the address). Converts it into a single valid/ready request and response transaction on the data bus. Drives dmem_wait, dmem_rdata and dmem_badmem_e back to the pipeline, and screens misaligned and out-of-range accesses before they reach the bus.

---
 rtl/vscale_dmem_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_vscale_dmem_bridge.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_dmem_bridge.sv
// rtl/vscale_dmem_bridge.sv - pipeline data-memory port to single valid/ready bus transaction bridge
// Optional response timeout is compiled in when VSCALE_DMEM_TIMEOUT_EN is defined.
module vscale_dmem_bridge #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK      = 32'hFFFF_0000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic        dmem_wait,
  output logic [31:0] dmem_rdata,
  output logic        dmem_badmem_e,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [3:0]  mem_req_wstrb,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  input  logic        mem_resp_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FAULT = 3'd1,
    S_REQ   = 3'd2,
    S_RESP  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_first_q, req_first_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        capture;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        out_of_range;
  logic        fault;
  logic [3:0]  strb_calc;
  logic        timeout_hit;

  // Size code 3 is not produced by the pipeline; it is treated like a word.
  logic unused_size_msb;
  assign unused_size_msb = dmem_size[2];

  // Capture is only possible in the states where dmem_wait is low.
  assign capture = dmem_en && ((state_q == S_IDLE) || (state_q == S_FAULT) || (state_q == S_DONE));

  assign is_half      = (dmem_size[1:0] == 2'b01);
  assign is_word      = dmem_size[1];
  assign misaligned   = (is_half && dmem_addr[0]) || (is_word && (dmem_addr[1:0] != 2'b00));
  assign out_of_range = ((dmem_addr & ADDR_MASK) != BASE_ADDR);
  assign fault        = misaligned || out_of_range;

  always_comb begin
    strb_calc = 4'b0000;
    if (dmem_wen) begin
      case (dmem_size[1:0])
        2'b00:   strb_calc = 4'b0001 << dmem_addr[1:0];
        2'b01:   strb_calc = 4'b0011 << {dmem_addr[1], 1'b0};
        default: strb_calc = 4'b1111;
      endcase
    end
  end

`ifdef VSCALE_DMEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign timeout_hit = (state_q == S_RESP) && !mem_resp_valid &&
                       (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_REQ)
      cnt_d = 8'd0;
    else if (state_q == S_RESP)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= 8'd0;
    else
      cnt_q <= cnt_d;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_FAULT, S_DONE: begin
        if (capture)
          state_d = fault ? S_FAULT : S_REQ;
        else
          state_d = S_IDLE;
      end
      S_REQ: begin
        if (mem_req_ready)
          state_d = S_RESP;
      end
      S_RESP: begin
        if (mem_resp_valid || timeout_hit)
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dmem_wait     = 1'b0;
    mem_req_valid = 1'b0;
    dmem_badmem_e = 1'b0;
    case (state_q)
      S_FAULT: dmem_badmem_e = 1'b1;
      S_REQ: begin
        dmem_wait     = 1'b1;
        mem_req_valid = 1'b1;
      end
      S_RESP:  dmem_wait     = 1'b1;
      S_DONE:  dmem_badmem_e = err_q;
      default: ;
    endcase
  end

  // Store data arrives in the first REQ cycle; pass it straight through then, hold it after.
  always_comb begin
    addr_d      = addr_q;
    wen_d       = wen_q;
    strb_d      = strb_q;
    wdata_d     = wdata_q;
    req_first_d = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    if (capture) begin
      addr_d      = {dmem_addr[31:2], 2'b00};
      wen_d       = dmem_wen;
      strb_d      = strb_calc;
      req_first_d = !fault;
    end
    if ((state_q == S_REQ) && req_first_q)
      wdata_d = dmem_wdata_delayed;
    if (state_q == S_RESP) begin
      if (mem_resp_valid) begin
        rdata_d = mem_resp_rdata;
        err_d   = mem_resp_err;
      end else if (timeout_hit) begin
        rdata_d = 32'h0;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= 32'h0;
      wen_q       <= 1'b0;
      strb_q      <= 4'h0;
      wdata_q     <= 32'h0;
      req_first_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      strb_q      <= strb_d;
      wdata_q     <= wdata_d;
      req_first_q <= req_first_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_req_addr  = addr_q;
  assign mem_req_wen   = wen_q;
  assign mem_req_wstrb = strb_q;
  assign mem_req_wdata = req_first_q ? dmem_wdata_delayed : wdata_q;
  assign dmem_rdata    = rdata_q;

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// tb/tb_vscale_dmem_bridge.sv - directed self-checking bench for vscale_dmem_bridge
module tb_vscale_dmem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmem_en;
  logic        dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata_delayed;
  logic        dmem_wait;
  logic [31:0] dmem_rdata;
  logic        dmem_badmem_e;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [3:0]  mem_req_wstrb;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        mem_resp_err;

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt   = 0;
  int hs_base;

  vscale_dmem_bridge dut (
    .clk                (clk),
    .reset              (reset),
    .dmem_en            (dmem_en),
    .dmem_wen           (dmem_wen),
    .dmem_size          (dmem_size),
    .dmem_addr          (dmem_addr),
    .dmem_wdata_delayed (dmem_wdata_delayed),
    .dmem_wait          (dmem_wait),
    .dmem_rdata         (dmem_rdata),
    .dmem_badmem_e      (dmem_badmem_e),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_addr       (mem_req_addr),
    .mem_req_wen        (mem_req_wen),
    .mem_req_wstrb      (mem_req_wstrb),
    .mem_req_wdata      (mem_req_wdata),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_rdata     (mem_resp_rdata),
    .mem_resp_err       (mem_resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset && mem_req_valid && mem_req_ready)
      hs_cnt <= hs_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic wen, input logic [2:0] size, input logic [31:0] addr);
    dmem_en   = 1'b1;
    dmem_wen  = wen;
    dmem_size = size;
    dmem_addr = addr;
  endtask

  initial begin
    reset = 1'b1;
    dmem_en = 1'b0; dmem_wen = 1'b0; dmem_size = 3'd0; dmem_addr = 32'h0;
    dmem_wdata_delayed = 32'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0; mem_resp_err = 1'b0;

    @(negedge clk);
    check_eq("rst_wait",   dmem_wait,     0);
    check_eq("rst_valid",  mem_req_valid, 0);
    check_eq("rst_badmem", dmem_badmem_e, 0);
    check_eq("rst_rdata",  dmem_rdata,    0);
    check_eq("rst_addr",   mem_req_addr,  0);
    check_eq("rst_wstrb",  mem_req_wstrb, 0);
    check_eq("rst_wdata",  mem_req_wdata, 0);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    @(negedge clk);
    check_eq("idle_valid", mem_req_valid, 0);

    // Word load, zero-wait slave
    next_cycle();
    drive_req(1'b0, 3'd2, 32'h0000_0010);
    mem_req_ready = 1'b1;
    @(negedge clk);
    check_eq("ld_addr_wait", dmem_wait, 0);
    next_cycle();
    dmem_en = 1'b0;
    @(negedge clk);
    check_eq("ld_req_valid", mem_req_valid, 1);
    check_eq("ld_req_addr",  mem_req_addr,  32'h10);
    check_eq("ld_req_wen",   mem_req_wen,   0);
    check_eq("ld_req_wstrb", mem_req_wstrb, 0);
    check_eq("ld_req_wait",  dmem_wait,     1);
    next_cycle();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("ld_resp_wait",  dmem_wait,     1);
    check_eq("ld_resp_valid", mem_req_valid, 0);
    next_cycle();
    mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
    @(negedge clk);
    check_eq("ld_done_wait",   dmem_wait,     0);
    check_eq("ld_done_rdata",  dmem_rdata,    32'hDEAD_BEEF);
    check_eq("ld_done_badmem", dmem_badmem_e, 0);
    next_cycle();
    @(negedge clk);
    check_eq("ld_hold_rdata", dmem_rdata, 32'hDEAD_BEEF);

    // Byte store at 0x23, ready delayed three cycles
    next_cycle();
    drive_req(1'b1, 3'd0, 32'h0000_0023);
    next_cycle();
    dmem_en = 1'b0;
    dmem_addr = 32'hFFFF_FFFF;
    dmem_wdata_delayed = 32'h5A5A_5A5A;
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3);
      @(negedge clk);
      check_eq($sformatf("st_valid_%0d", i), mem_req_valid, 1);
      check_eq($sformatf("st_addr_%0d", i),  mem_req_addr,  32'h20);
      check_eq($sformatf("st_wstrb_%0d", i), mem_req_wstrb, 4'b1000);
      check_eq($sformatf("st_wdata_%0d", i), mem_req_wdata, 32'h5A5A_5A5A);
      check_eq($sformatf("st_wen_%0d", i),   mem_req_wen,   1);
      check_eq($sformatf("st_wait_%0d", i),  dmem_wait,     1);
      next_cycle();
    end
    mem_req_ready = 1'b0;
    dmem_wdata_delayed = 32'h0;
    @(negedge clk);
    check_eq("st_resp_wait0", dmem_wait, 1);
    next_cycle();
    mem_resp_valid = 1'b1;
    @(negedge clk);
    check_eq("st_resp_wait1", dmem_wait, 1);
    next_cycle();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check_eq("st_done_wait",   dmem_wait,     0);
    check_eq("st_done_badmem", dmem_badmem_e, 0);
    next_cycle();

    // Misaligned half load -> fault, no bus activity
    hs_base = hs_cnt;
    drive_req(1'b0, 3'd1, 32'h0000_0001);
    mem_req_ready = 1'b1;
    @(negedge clk);
    check_eq("mis_addr_wait", dmem_wait, 0);
    next_cycle();
    dmem_en = 1'b0;
    @(negedge clk);
    check_eq("mis_badmem", dmem_badmem_e, 1);
    check_eq("mis_wait",   dmem_wait,     0);
    check_eq("mis_valid",  mem_req_valid, 0);
    next_cycle();
    @(negedge clk);
    check_eq("mis_after_badmem", dmem_badmem_e, 0);
    check_eq("mis_after_valid",  mem_req_valid, 0);
    check_eq("mis_hs", hs_cnt - hs_base, 0);

    // Out-of-range word load, then a legal load captured in the fault cycle
    next_cycle();
    drive_req(1'b0, 3'd2, 32'h0001_0000);
    next_cycle();
    drive_req(1'b0, 3'd2, 32'h0000_0004);
    @(negedge clk);
    check_eq("oor_badmem", dmem_badmem_e, 1);
    check_eq("oor_valid",  mem_req_valid, 0);
    check_eq("oor_wait",   dmem_wait,     0);
    next_cycle();
    dmem_en = 1'b0;
    @(negedge clk);
    check_eq("oor_hs", hs_cnt - hs_base, 0);
    check_eq("leg_valid", mem_req_valid, 1);
    check_eq("leg_addr",  mem_req_addr,  32'h4);
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234_5678;
    next_cycle();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check_eq("leg_done_rdata",  dmem_rdata,    32'h1234_5678);
    check_eq("leg_done_badmem", dmem_badmem_e, 0);
    check_eq("leg_done_wait",   dmem_wait,     0);
    next_cycle();

    // Back-to-back load then store with dmem_en held through the stall
    hs_base = hs_cnt;
    drive_req(1'b0, 3'd2, 32'h0000_0008);
    mem_req_ready = 1'b1;
    next_cycle();
    drive_req(1'b1, 3'd2, 32'h0000_000C);
    @(negedge clk);
    check_eq("b2b_ld_addr", mem_req_addr, 32'h8);
    check_eq("b2b_ld_wen",  mem_req_wen,  0);
    next_cycle();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1111_1111;
    @(negedge clk);
    check_eq("b2b_resp_wait", dmem_wait, 1);
    next_cycle();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check_eq("b2b_ld_rdata", dmem_rdata, 32'h1111_1111);
    check_eq("b2b_ld_wait",  dmem_wait,  0);
    next_cycle();
    dmem_en = 1'b0;
    dmem_wdata_delayed = 32'hCAFE_F00D;
    @(negedge clk);
    check_eq("b2b_st_valid", mem_req_valid, 1);
    check_eq("b2b_st_addr",  mem_req_addr,  32'hC);
    check_eq("b2b_st_wen",   mem_req_wen,   1);
    check_eq("b2b_st_wstrb", mem_req_wstrb, 4'hF);
    check_eq("b2b_st_wdata", mem_req_wdata, 32'hCAFE_F00D);
    next_cycle();
    mem_req_ready = 1'b0;
    dmem_wdata_delayed = 32'h0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h7777_7777;
    next_cycle();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check_eq("b2b_st_badmem", dmem_badmem_e, 0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("b2b_hs",    hs_cnt - hs_base, 2);
    check_eq("b2b_idle",  mem_req_valid,    0);
    check_eq("b2b_rdata", dmem_rdata,       32'h7777_7777);

    // Reset during RESP, then a late response
    next_cycle();
    drive_req(1'b0, 3'd2, 32'h0000_0014);
    mem_req_ready = 1'b1;
    next_cycle();
    dmem_en = 1'b0;
    next_cycle();
    mem_req_ready = 1'b0;
    @(negedge clk);
    check_eq("rr_pre_wait", dmem_wait, 1);
    next_cycle();
    reset = 1'b1;
    #1;
    check_eq("rr_wait",   dmem_wait,     0);
    check_eq("rr_rdata",  dmem_rdata,    0);
    check_eq("rr_valid",  mem_req_valid, 0);
    check_eq("rr_addr",   mem_req_addr,  0);
    check_eq("rr_badmem", dmem_badmem_e, 0);
    next_cycle();
    reset = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBAD0_BAD0; mem_resp_err = 1'b1;
    @(negedge clk);
    check_eq("rr_late_wait", dmem_wait, 0);
    next_cycle();
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    @(negedge clk);
    check_eq("rr_late_rdata",  dmem_rdata,    0);
    check_eq("rr_late_badmem", dmem_badmem_e, 0);
    check_eq("rr_late_valid",  mem_req_valid, 0);

`ifdef VSCALE_DMEM_TIMEOUT_EN
    begin
      int resp_cycles;
      bit done;
      next_cycle();
      drive_req(1'b0, 3'd2, 32'h0000_0018);
      mem_req_ready = 1'b1;
      next_cycle();
      dmem_en = 1'b0;
      next_cycle();
      mem_req_ready = 1'b0;
      resp_cycles = 0;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
        @(negedge clk);
        if (!dmem_wait) done = 1'b1;
        else resp_cycles++;
        if (!done) next_cycle();
      end
      check_eq("to_done",   done,          1);
      check_eq("to_cycles", resp_cycles,   64);
      check_eq("to_badmem", dmem_badmem_e, 1);
      check_eq("to_rdata",  dmem_rdata,    0);
      next_cycle();
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5555_5555;
      next_cycle();
      mem_resp_valid = 1'b0;
      @(negedge clk);
      check_eq("to_stray_rdata", dmem_rdata, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
